// File: rtl/gemm_core_pkg.sv
// Shared types, widths and small helpers for the GEMM compute core.
package gemm_core_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int PSUM_WIDTH      = 32;
    localparam int VECTOR_LENGTH   = 16;
    localparam int IMEM_ADDR_WIDTH = 6;
    localparam int WMEM_ADDR_WIDTH = 6;
    localparam int OMEM_ADDR_WIDTH = 10;
    localparam int DIM_L_WIDTH     = 32;
    localparam int DIM_M_WIDTH     = 32;
    localparam int DIM_N_WIDTH     = 32;
    localparam int KT_WIDTH        = DIM_L_WIDTH - 4;
    localparam int LANE_IDX_WIDTH  = $clog2(VECTOR_LENGTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } gemm_state_e;

    // Number of 16-lane chunks covering L; the sum wraps in DIM_L_WIDTH bits.
    function automatic logic [KT_WIDTH-1:0] kt_of(input logic [DIM_L_WIDTH-1:0] dim_l);
        logic [DIM_L_WIDTH-1:0] l_plus;
        l_plus = dim_l + 32'd15;
        return l_plus[DIM_L_WIDTH-1:4];
    endfunction

    // Lanes of chunk k that fall below L (only meaningful for k < KT).
    function automatic logic [LANE_IDX_WIDTH:0] lanes_valid(input logic [DIM_L_WIDTH-1:0] dim_l,
                                                           input logic [KT_WIDTH-1:0]    k);
        logic [DIM_L_WIDTH-1:0] rem;
        rem = dim_l - {k, {LANE_IDX_WIDTH{1'b0}}};
        if (rem >= 32'd16) begin
            return (LANE_IDX_WIDTH+1)'(VECTOR_LENGTH);
        end else begin
            return rem[LANE_IDX_WIDTH:0];
        end
    endfunction

endpackage

// File: rtl/gemm_core_vector_dot.sv
// Combinational 16-lane signed dot product with lane masking and a binary adder tree.
module vector_dot
    import gemm_core_pkg::*;
#(
    parameter int DATA_WIDTH    = gemm_core_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH    = gemm_core_pkg::PSUM_WIDTH,
    parameter int VECTOR_LENGTH = gemm_core_pkg::VECTOR_LENGTH,
    parameter int LANE_W        = $clog2(VECTOR_LENGTH)
) (
    input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] a_vec,
    input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] b_vec,
    input  logic [LANE_W:0]                     lanes,
    output logic [PSUM_WIDTH-1:0]               sum
);

    for (genvar lv = 0; lv <= LANE_W; lv++) begin : g_lvl
        localparam int NODES = VECTOR_LENGTH >> lv;
        logic [PSUM_WIDTH-1:0] sum_s [NODES];

        if (lv == 0) begin : g_leaf
            for (genvar p = 0; p < NODES; p++) begin : g_lane
                localparam logic [LANE_W:0] LANE_ID = (LANE_W+1)'(p);
                // Products keep only the low bits; masked lanes ignore rdata entirely.
                assign sum_s[p] = (LANE_ID < lanes)
                    ? PSUM_WIDTH'($signed(a_vec[p*DATA_WIDTH +: DATA_WIDTH]) *
                                  $signed(b_vec[p*DATA_WIDTH +: DATA_WIDTH]))
                    : {PSUM_WIDTH{1'b0}};
            end
        end else begin : g_add
            for (genvar n = 0; n < NODES; n++) begin : g_node
                assign sum_s[n] = g_lvl[lv-1].sum_s[2*n] + g_lvl[lv-1].sum_s[2*n+1];
            end
        end
    end

    assign sum = g_lvl[LANE_W].sum_s[0];

endmodule

// File: rtl/gemm_core.sv
// GEMM compute core: walks the MxN output grid, streams KT vector chunks per element and writes one word each.
module gemm_core
    import gemm_core_pkg::*;
#(
    parameter int DATA_WIDTH      = gemm_core_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH      = gemm_core_pkg::PSUM_WIDTH,
    parameter int VECTOR_LENGTH   = gemm_core_pkg::VECTOR_LENGTH,
    parameter int IMEM_ADDR_WIDTH = gemm_core_pkg::IMEM_ADDR_WIDTH,
    parameter int WMEM_ADDR_WIDTH = gemm_core_pkg::WMEM_ADDR_WIDTH,
    parameter int OMEM_ADDR_WIDTH = gemm_core_pkg::OMEM_ADDR_WIDTH,
    parameter int DIM_L_WIDTH     = gemm_core_pkg::DIM_L_WIDTH,
    parameter int DIM_M_WIDTH     = gemm_core_pkg::DIM_M_WIDTH,
    parameter int DIM_N_WIDTH     = gemm_core_pkg::DIM_N_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [DIM_L_WIDTH-1:0]              dim_l,
    input  logic [DIM_M_WIDTH-1:0]              dim_m,
    input  logic [DIM_N_WIDTH-1:0]              dim_n,
    output logic                                busy,
    output logic                                done,
    output logic                                imem_en,
    output logic [IMEM_ADDR_WIDTH-1:0]          imem_addr,
    input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] imem_rdata,
    output logic                                wmem_en,
    output logic [WMEM_ADDR_WIDTH-1:0]          wmem_addr,
    input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] wmem_rdata,
    output logic                                omem_we,
    output logic [OMEM_ADDR_WIDTH-1:0]          omem_addr,
    output logic [PSUM_WIDTH-1:0]               omem_wdata
);

    gemm_state_e                 state_q, state_d;
    logic [KT_WIDTH-1:0]         kt_q, kt_d, k_q, k_d, kv_q, kv_d;
    logic [DIM_L_WIDTH-1:0]      l_q, l_d;
    logic [DIM_M_WIDTH-1:0]      m_q, m_d, i_q, i_d;
    logic [DIM_N_WIDTH-1:0]      n_q, n_d, j_q, j_d;
    logic [IMEM_ADDR_WIDTH-1:0]  ibase_q, ibase_d, imem_addr_q, imem_addr_d;
    logic [WMEM_ADDR_WIDTH-1:0]  wbase_q, wbase_d, wmem_addr_q, wmem_addr_d;
    logic [OMEM_ADDR_WIDTH-1:0]  oidx_q, oidx_d, omem_addr_q, omem_addr_d;
    logic [PSUM_WIDTH-1:0]       acc_q, acc_d, omem_wdata_q, omem_wdata_d;
    logic                        vld_q, vld_d, fetch_en_q, fetch_en_d;
    logic                        busy_q, busy_d, done_q, done_d, omem_we_q, omem_we_d;
    logic [LANE_IDX_WIDTH:0]     lanes_s;
    logic [PSUM_WIDTH-1:0]       dot_s;

    assign lanes_s = lanes_valid(l_q, kv_q);

    vector_dot #(
        .DATA_WIDTH    (DATA_WIDTH),
        .PSUM_WIDTH    (PSUM_WIDTH),
        .VECTOR_LENGTH (VECTOR_LENGTH),
        .LANE_W        (LANE_IDX_WIDTH)
    ) u_dot (
        .a_vec (imem_rdata),
        .b_vec (wmem_rdata),
        .lanes (lanes_s),
        .sum   (dot_s)
    );

    // Next-state, counter, accumulator and registered-output logic.
    always_comb begin
        state_d      = state_q;
        kt_d         = kt_q;
        k_d          = k_q;
        l_d          = l_q;
        m_d          = m_q;
        n_d          = n_q;
        i_d          = i_q;
        j_d          = j_q;
        ibase_d      = ibase_q;
        wbase_d      = wbase_q;
        oidx_d       = oidx_q;
        omem_we_d    = 1'b0;
        omem_addr_d  = omem_addr_q;
        omem_wdata_d = omem_wdata_q;
        vld_d        = fetch_en_q;
        kv_d         = k_q;
        if (vld_q) begin
            acc_d = acc_q + dot_s;
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    l_d     = dim_l;
                    m_d     = dim_m;
                    n_d     = dim_n;
                    kt_d    = kt_of(dim_l);
                    k_d     = {KT_WIDTH{1'b0}};
                    i_d     = {DIM_M_WIDTH{1'b0}};
                    j_d     = {DIM_N_WIDTH{1'b0}};
                    ibase_d = {IMEM_ADDR_WIDTH{1'b0}};
                    wbase_d = {WMEM_ADDR_WIDTH{1'b0}};
                    oidx_d  = {OMEM_ADDR_WIDTH{1'b0}};
                    acc_d   = {PSUM_WIDTH{1'b0}};
                    if ((dim_l == {DIM_L_WIDTH{1'b0}}) || (dim_m == {DIM_M_WIDTH{1'b0}}) ||
                        (dim_n == {DIM_N_WIDTH{1'b0}})) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (k_q == kt_q - KT_WIDTH'(1'b1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + KT_WIDTH'(1'b1);
                end
            end
            ST_DRAIN: begin
                // The last chunk lands here, so the written word includes it.
                state_d      = ST_WRITE;
                omem_we_d    = 1'b1;
                omem_addr_d  = oidx_q;
                omem_wdata_d = acc_d;
            end
            ST_WRITE: begin
                acc_d  = {PSUM_WIDTH{1'b0}};
                oidx_d = oidx_q + OMEM_ADDR_WIDTH'(1'b1);
                k_d    = {KT_WIDTH{1'b0}};
                if (j_q == n_q - DIM_N_WIDTH'(1'b1)) begin
                    j_d     = {DIM_N_WIDTH{1'b0}};
                    wbase_d = {WMEM_ADDR_WIDTH{1'b0}};
                    if (i_q == m_q - DIM_M_WIDTH'(1'b1)) begin
                        state_d = ST_DONE;
                    end else begin
                        i_d     = i_q + DIM_M_WIDTH'(1'b1);
                        ibase_d = ibase_q + kt_q[IMEM_ADDR_WIDTH-1:0];
                        state_d = ST_FETCH;
                    end
                end else begin
                    j_d     = j_q + DIM_N_WIDTH'(1'b1);
                    wbase_d = wbase_q + kt_q[WMEM_ADDR_WIDTH-1:0];
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they are registered with it.
        fetch_en_d = (state_d == ST_FETCH);
        if (fetch_en_d) begin
            imem_addr_d = ibase_d + k_d[IMEM_ADDR_WIDTH-1:0];
            wmem_addr_d = wbase_d + k_d[WMEM_ADDR_WIDTH-1:0];
        end else begin
            imem_addr_d = imem_addr_q;
            wmem_addr_d = wmem_addr_q;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            kt_q         <= {KT_WIDTH{1'b0}};
            k_q          <= {KT_WIDTH{1'b0}};
            kv_q         <= {KT_WIDTH{1'b0}};
            l_q          <= {DIM_L_WIDTH{1'b0}};
            m_q          <= {DIM_M_WIDTH{1'b0}};
            n_q          <= {DIM_N_WIDTH{1'b0}};
            i_q          <= {DIM_M_WIDTH{1'b0}};
            j_q          <= {DIM_N_WIDTH{1'b0}};
            ibase_q      <= {IMEM_ADDR_WIDTH{1'b0}};
            wbase_q      <= {WMEM_ADDR_WIDTH{1'b0}};
            oidx_q       <= {OMEM_ADDR_WIDTH{1'b0}};
            acc_q        <= {PSUM_WIDTH{1'b0}};
            vld_q        <= 1'b0;
            fetch_en_q   <= 1'b0;
            imem_addr_q  <= {IMEM_ADDR_WIDTH{1'b0}};
            wmem_addr_q  <= {WMEM_ADDR_WIDTH{1'b0}};
            omem_we_q    <= 1'b0;
            omem_addr_q  <= {OMEM_ADDR_WIDTH{1'b0}};
            omem_wdata_q <= {PSUM_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            kt_q         <= kt_d;
            k_q          <= k_d;
            kv_q         <= kv_d;
            l_q          <= l_d;
            m_q          <= m_d;
            n_q          <= n_d;
            i_q          <= i_d;
            j_q          <= j_d;
            ibase_q      <= ibase_d;
            wbase_q      <= wbase_d;
            oidx_q       <= oidx_d;
            acc_q        <= acc_d;
            vld_q        <= vld_d;
            fetch_en_q   <= fetch_en_d;
            imem_addr_q  <= imem_addr_d;
            wmem_addr_q  <= wmem_addr_d;
            omem_we_q    <= omem_we_d;
            omem_addr_q  <= omem_addr_d;
            omem_wdata_q <= omem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign imem_en    = fetch_en_q;
    assign wmem_en    = fetch_en_q;
    assign imem_addr  = imem_addr_q;
    assign wmem_addr  = wmem_addr_q;
    assign omem_we    = omem_we_q;
    assign omem_addr  = omem_addr_q;
    assign omem_wdata = omem_wdata_q;

endmodule

// File: doc/gemm_core.md
# gemm_core

Compute core of the GEMM RTL kernel. It sits directly downstream of the input/weight vector memories and upstream of the output memory. On `start` it walks an M×N output grid. For each output element it streams the L-long input row and weight column as 16-lane, 32-bit vectors, reduces them in a 16-lane SIMD dot product, and writes one 32-bit result word to the output memory.

## Interface
Parameters (defaults from the kernel package):
- DATA_WIDTH, 32, lane operand width
- PSUM_WIDTH, 32, accumulator/result width
- VECTOR_LENGTH, 16, lanes per memory word
- IMEM_ADDR_WIDTH, 6, input memory address width
- WMEM_ADDR_WIDTH, 6, weight memory address width
- OMEM_ADDR_WIDTH, 10, output memory address width
- DIM_L_WIDTH / DIM_M_WIDTH / DIM_N_WIDTH, 32, dimension register widths

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin operation; sampled only in IDLE
- dim_l / dim_m / dim_n  in  32 each  GEMM dimensions; latched on accepted start
- busy  out  1  high from the cycle after accepted start until DONE, inclusive
- done  out  1  one-cycle pulse in DONE
- imem_en  out  1  input memory read enable
- imem_addr  out  6  input vector address
- imem_rdata  in  512  input vector; valid one cycle after imem_en
- wmem_en / wmem_addr / wmem_rdata  out/out/in  1/6/512  weight memory port; same rules as the input port
- omem_we  out  1  output write strobe
- omem_addr  out  10  output word address
- omem_wdata  out  32  output word

## Operation
- KT = ceil(L/16), computed at start as (dim_l+15)>>4.
- Loop order: i over 0..M-1 (outer), j over 0..N-1, k over 0..KT-1 (inner).
- Input is stored row-major: imem_addr = i*KT+k.
- Weight is stored transposed (N×L): wmem_addr = j*KT+k.
- Output address: omem_addr = i*N+j.
- All addresses are truncated to the port width. Wrap-around is the caller's responsibility.
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE → FETCH on start when all dims are nonzero.
- IDLE → DONE on start when any dim is 0. No memory access occurs in that case.
- FETCH lasts exactly KT cycles. imem_en and wmem_en are both 1 every cycle, with k incrementing. Then FETCH → DRAIN.
- DRAIN lasts 1 cycle; it accumulates the last vector. DRAIN → WRITE.
- WRITE lasts 1 cycle: omem_we=1, omem_wdata=acc.
- After WRITE: advance j, and on wrap advance i. Go to FETCH, or to DONE after element (M-1, N-1).
- DONE lasts 1 cycle with done=1, then → IDLE.
- A valid flag follows each issued read by 1 cycle. Data tagged with chunk k is accumulated in the cycle it is valid.
- acc is cleared in WRITE and on entry to FETCH.
- Lane masking: lane p of chunk k contributes 0 when k*16+p ≥ L, regardless of rdata.
- Arithmetic: each lane does a signed 32×32 multiply, truncated to the low 32 bits. Lane sum and accumulation wrap modulo 2^32. There is no saturation.
- start while busy is ignored. Dimension inputs are ignored after latching.
- rst at any cycle forces IDLE, clears counters and acc, and drives all outputs to 0. A partially computed element is never written.

## Timing
- Reset values: busy=0, done=0, imem_en=0, wmem_en=0, omem_we=0, and every address and data output is 0.
- Let start be accepted at edge t0. Then:
  - FETCH covers cycles t0+1 .. t0+KT
  - DRAIN is at t0+KT+1
  - the first WRITE is at t0+KT+2
- Cycles per output element: KT+2.
- done occurs at t0 + M*N*(KT+2) + 1. With any dim 0, done occurs at t0+1.
- Memory read latency is fixed at 1 cycle. There is no back-pressure.
- omem_addr and omem_wdata are valid only while omem_we=1. Otherwise they hold their last value.

## Structure
- Kernel package gains:
  - `gemm_state_e` enum for the five states
  - `KT_WIDTH = DIM_L_WIDTH-4`
  - `LANE_IDX_WIDTH = $clog2(VECTOR_LENGTH)`
- Sub-module `vector_dot`: combinational 16-lane signed multiply with lane mask (inputs: two 512-bit vectors, valid-lane count 1..16) and adder tree, producing a 32-bit sum.
- `gemm_core` holds the FSM, counters, address generation and accumulator.

## Test plan
- L=16, M=N=1, all lanes 1 → single write omem[0]=16; done exactly 4 cycles after the start edge.
- L=20, M=N=1, lanes 0..19 =2 and =3, with lanes 4..15 of the second word filled with 0xDEADBEEF → omem[0]=120 (masking verified).
- L=32, M=2, N=3, random signed data → 6 writes in order addrs 0,1,2,3,4,5 matching a golden model; 4 cycles per element.
- Operands 0x7FFFFFFF×2 in lane 0, L=1 → omem[0]=0xFFFFFFFE (modulo wrap).
- dim_m=0 → no en/we asserted; done at t0+1. A start pulsed while busy → ignored, outputs unchanged.
- rst asserted mid-FETCH of the second element → next cycle all outputs 0 and state IDLE; no write for the interrupted element; a fresh start then completes correctly.
